// File: rtl/addsub_dispatch.sv
// addsub_dispatch: two's-complement front end sequencing a sign-magnitude add/sub unit
module addsub_dispatch #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op_sub,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        timeout,
    output logic [31:0] as_a,
    output logic [31:0] as_b,
    output logic [3:0]  as_control,
    output logic        as_start,
    input  logic        as_finish,
    input  logic [31:0] as_c,
    input  logic        as_sign
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic sb;
    logic [31:0] cap;
    logic cap_ovf;
    // Effective B sign, and the unit's magnitude/sign converted back to two's complement.
    // as_control[1:0] hold the latched A sign and effective B sign during WAIT.
    always_comb begin
        sb = opb[31] ^ op_sub;
        cap = (as_sign && as_c != 32'd0) ? ~as_c + 32'd1 : as_c;
        cap_ovf = (as_control[1] == as_control[0]) && (cap[31] != as_control[1]) && (cap != 32'd0);
    end
    // Sequencer: accept, pulse start, wait for finish or timeout, hold result until consumed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            in_ready <= 1'b1;
            as_start <= 1'b0;
            out_valid <= 1'b0;
            overflow <= 1'b0;
            timeout <= 1'b0;
            result <= 32'd0;
            as_a <= 32'd0;
            as_b <= 32'd0;
            as_control <= 4'b1000;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    as_a <= opa[31] ? ~opa + 32'd1 : opa;
                    as_b <= opb[31] ? ~opb + 32'd1 : opb;
                    as_control <= {2'b10, opa[31], sb};
                    in_ready <= 1'b0;
                    as_start <= 1'b1;
                    cnt <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    as_start <= 1'b0;
                    state <= WAIT;
                end
                WAIT: if (as_finish) begin
                    result <= cap;
                    overflow <= cap_ovf;
                    timeout <= 1'b0;
                    out_valid <= 1'b1;
                    state <= HOLD;
                end else if (cnt == LAST) begin
                    result <= 32'd0;
                    overflow <= 1'b0;
                    timeout <= 1'b1;
                    out_valid <= 1'b1;
                    state <= HOLD;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_dispatch.sv
// tb_addsub_dispatch: directed checks of addsub_dispatch against a behavioural add/sub model
module tb_addsub_dispatch;
    localparam int T = 8;
    logic clock = 0, reset = 1, in_valid = 0, op_sub = 0, out_ready = 0;
    logic [31:0] opa = 0, opb = 0;
    logic in_ready, out_valid, overflow, timeout, as_start;
    logic [31:0] result, as_a, as_b, as_c;
    logic [3:0] as_control;
    logic as_finish, as_sign;
    logic fin = 0, force_fin = 0, never = 0, sgn_r = 0;
    logic [31:0] c_r = 0;
    int dly = 0;
    int pass = 0, total = 0;
    logic [31:0] exp_res = 0;
    logic exp_ovf = 0, exp_to = 0;

    assign as_finish = fin | force_fin;
    assign as_c = c_r;
    assign as_sign = sgn_r;

    addsub_dispatch #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .timeout(timeout), .as_a(as_a), .as_b(as_b), .as_control(as_control),
        .as_start(as_start), .as_finish(as_finish), .as_c(as_c), .as_sign(as_sign)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Sign-magnitude unit behaviour: {sign, |signed(A) +/- signed(B)|}
    function automatic logic [32:0] unit_calc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
        longint la, lb, v;
        la = {32'd0, a};
        lb = {32'd0, b};
        v = (ctl[1] ? -la : la) + (ctl[0] ? -lb : lb);
        unit_calc = v < 0 ? {1'b1, 32'(-v)} : {1'b0, 32'(v)};
    endfunction

    // Add/sub unit model: finish rises two edges after start, drops once the result is presented
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fin <= 0;
            dly <= 0;
        end else begin
            if (as_start && !never) begin
                {sgn_r, c_r} <= unit_calc(as_a, as_b, as_control);
                dly <= 2;
            end else if (dly > 1) dly <= dly - 1;
            else if (dly == 1) begin
                fin <= 1;
                dly <= 0;
            end
            if (out_valid) fin <= 0;
        end
    end

    // Every presented result must match the arithmetic model of the accepted request
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            check("model_result", result, exp_res);
            check("model_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            check("model_timeout", {31'd0, timeout}, {31'd0, exp_to});
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [3:0] l_ctl, input logic [31:0] l_a, input logic [31:0] l_b,
                          input logic [31:0] l_res, input logic l_ovf, input logic l_to, input int hold);
        longint s;
        int n;
        @(negedge clock);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        opa = a; opb = b; op_sub = sub; in_valid = 1;
        s = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
        exp_to = never;
        exp_res = never ? 32'd0 : 32'(s);
        exp_ovf = !never && (s > 64'sd2147483647 || s < -64'sd2147483648);
        @(negedge clock);
        in_valid = 0;
        check("issue_start", {31'd0, as_start}, 32'd1);
        check("issue_ctl", {28'd0, as_control}, {28'd0, l_ctl});
        check("issue_a", as_a, l_a);
        check("issue_b", as_b, l_b);
        @(negedge clock);
        check("wait_start_low", {31'd0, as_start}, 32'd0);
        check("wait_ctl_stable", {28'd0, as_control}, {28'd0, l_ctl});
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (l_to) check("timeout_latency", n, T);
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        check("lit_result", result, l_res);
        check("lit_overflow", {31'd0, overflow}, {31'd0, l_ovf});
        check("lit_timeout", {31'd0, timeout}, {31'd0, l_to});
        repeat (hold) begin
            @(negedge clock);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, l_res);
        end
        out_ready = 1;
        @(negedge clock);
        out_ready = 0;
        check("exit_valid", {31'd0, out_valid}, 32'd0);
        check("exit_in_ready", {31'd0, in_ready}, 32'd1);
        check("flags_held", {30'd0, timeout, overflow}, {30'd0, l_to, l_ovf});
    endtask

    initial begin
        @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_ctl", {28'd0, as_control}, 32'd8);
        check("rst_outs", {as_a | as_b | result}, 32'd0);
        check("rst_flags", {28'd0, as_start, out_valid, overflow, timeout}, 32'd0);
        reset = 0;
        run_op(32'd5, 32'd7, 0, 4'b1000, 32'd5, 32'd7, 32'h0000000C, 0, 0, 0);
        run_op(32'd5, 32'd7, 1, 4'b1001, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 1);
        run_op(32'hFFFFFFFD, 32'hFFFFFFFC, 0, 4'b1011, 32'd3, 32'd4, 32'hFFFFFFF9, 0, 0, 0);
        run_op(32'h7FFFFFFF, 32'd1, 0, 4'b1000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 0);
        run_op(32'h80000000, 32'd1, 1, 4'b1011, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1, 0, 0);
        run_op(32'd5, 32'd0, 1, 4'b1001, 32'd5, 32'd0, 32'd5, 0, 0, 0);
        never = 1;
        run_op(32'd1, 32'd2, 0, 4'b1000, 32'd1, 32'd2, 32'd0, 0, 1, 4);
        @(negedge clock);
        opa = 32'hFFFFFFFF; opb = 32'd9; op_sub = 0; in_valid = 1;
        @(negedge clock);
        in_valid = 0;
        check("rw_start", {31'd0, as_start}, 32'd1);
        repeat (2) @(negedge clock);
        reset = 1;
        #1;
        check("rw_in_ready", {31'd0, in_ready}, 32'd1);
        check("rw_ctl", {28'd0, as_control}, 32'd8);
        check("rw_mag", as_a | as_b | result, 32'd0);
        check("rw_flags", {28'd0, as_start, out_valid, overflow, timeout}, 32'd0);
        @(negedge clock);
        reset = 0;
        never = 0;
        force_fin = 1;
        repeat (3) begin
            @(negedge clock);
            check("stale_finish_ignored", {30'd0, out_valid, in_ready}, 32'd1);
        end
        force_fin = 0;
        run_op(32'hFFFFFFF6, 32'd4, 1, 4'b1011, 32'd10, 32'd4, 32'hFFFFFFF2, 0, 0, 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
